// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: turns PC/chip-enable fetches into single req/gnt/rvalid bus reads.
// Optional bus timeout with bus_err_o output is enabled by defining INST_FETCH_TIMEOUT_EN.
module inst_fetch_bridge #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              ce_i,
   input  logic              flush,
   input  logic              stall_i,
   output logic              bus_req_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   input  logic              bus_gnt_i,
   input  logic              bus_rvalid_i,
   input  logic [DATA_W-1:0] bus_rdata_i,
   output logic [DATA_W-1:0] inst_o,
   output logic              inst_valid_o,
   output logic              adel_o,
`ifdef INST_FETCH_TIMEOUT_EN
   output logic              bus_err_o,
`endif
   output logic              stallreq_o
);

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StWait,
      StDone,
      StDiscard
   } state_e;

   state_e            r_state;
   logic              r_bus_req;
   logic [ADDR_W-1:0] r_bus_addr;
   logic [DATA_W-1:0] r_inst;
   logic              r_inst_valid;
   logic              r_adel;
   logic              r_discard;
   logic              w_timeout;

`ifdef INST_FETCH_TIMEOUT_EN
   localparam int unsigned CNT_W =
      ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [CNT_W-1:0] r_cnt;
   logic             r_bus_err;

   assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Counter restarts on every entry to WAIT or DISCARD, including WAIT->DISCARD on flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_bus_err <= 1'b0;
      end else begin
         if ((r_state != StWait && r_state != StDiscard) || (r_state == StWait && flush)) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end

         if (r_state == StWait && !flush && !bus_rvalid_i && w_timeout) begin
            r_bus_err <= 1'b1;
         end else if (r_state == StDone && (flush || !stall_i)) begin
            r_bus_err <= 1'b0;
         end
      end
   end

   assign bus_err_o = r_bus_err;
`else
   logic w_unused_timeout;

   assign w_timeout        = 1'b0;
   assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= StIdle;
         r_bus_req    <= 1'b0;
         r_bus_addr   <= '0;
         r_inst       <= '0;
         r_inst_valid <= 1'b0;
         r_adel       <= 1'b0;
         r_discard    <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (flush) begin
                  r_inst_valid <= 1'b0;
                  r_adel       <= 1'b0;
               end else if (ce_i) begin
                  if (pc_i[1:0] != 2'b00) begin
                     r_inst       <= '0;
                     r_adel       <= 1'b1;
                     r_inst_valid <= 1'b1;
                     r_state      <= StDone;
                  end else begin
                     r_bus_addr <= pc_i;
                     r_bus_req  <= 1'b1;
                     r_state    <= StReq;
                  end
               end
            end

            StReq: begin
               if (bus_gnt_i) begin
                  r_bus_req <= 1'b0;
                  r_discard <= 1'b0;
                  // A flush seen now or while waiting for grant kills this response.
                  if (flush || r_discard) begin
                     r_state <= bus_rvalid_i ? StIdle : StDiscard;
                  end else if (bus_rvalid_i) begin
                     r_inst       <= bus_rdata_i;
                     r_adel       <= 1'b0;
                     r_inst_valid <= 1'b1;
                     r_state      <= StDone;
                  end else begin
                     r_state <= StWait;
                  end
               end else if (flush) begin
                  r_discard <= 1'b1;
               end
            end

            StWait: begin
               if (flush) begin
                  r_state <= bus_rvalid_i ? StIdle : StDiscard;
               end else if (bus_rvalid_i) begin
                  r_inst       <= bus_rdata_i;
                  r_adel       <= 1'b0;
                  r_inst_valid <= 1'b1;
                  r_state      <= StDone;
               end else if (w_timeout) begin
                  r_inst       <= '0;
                  r_adel       <= 1'b0;
                  r_inst_valid <= 1'b1;
                  r_state      <= StDone;
               end
            end

            StDone: begin
               if (flush) begin
                  r_inst_valid <= 1'b0;
                  r_adel       <= 1'b0;
                  r_state      <= StIdle;
               end else if (!stall_i) begin
                  r_inst_valid <= 1'b0;
                  r_state      <= StIdle;
               end
            end

            StDiscard: begin
               if (bus_rvalid_i || w_timeout) begin
                  r_state <= StIdle;
               end
            end

            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign stallreq_o   = (r_state == StReq) || (r_state == StWait) || (r_state == StDiscard) ||
                         (r_state == StIdle && ce_i && !flush);
   assign bus_req_o    = r_bus_req;
   assign bus_addr_o   = r_bus_addr;
   assign inst_o       = r_inst;
   assign inst_valid_o = r_inst_valid;
   assign adel_o       = r_adel;

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed self-checking bench for inst_fetch_bridge; timeout case runs when
// INST_FETCH_TIMEOUT_EN is defined.
module tb_inst_fetch_bridge;

   logic        clk;
   logic        rst;
   logic [31:0] pc_i;
   logic        ce_i;
   logic        flush;
   logic        stall_i;
   logic        bus_req_o;
   logic [31:0] bus_addr_o;
   logic        bus_gnt_i;
   logic        bus_rvalid_i;
   logic [31:0] bus_rdata_i;
   logic [31:0] inst_o;
   logic        inst_valid_o;
   logic        adel_o;
   logic        stallreq_o;
`ifdef INST_FETCH_TIMEOUT_EN
   logic        bus_err_o;
`endif

   int unsigned n_checks;
   int unsigned n_errors;

   inst_fetch_bridge #(
      .ADDR_W        (32),
      .DATA_W        (32),
      .TIMEOUT_CYCLES(4)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .pc_i        (pc_i),
      .ce_i        (ce_i),
      .flush       (flush),
      .stall_i     (stall_i),
      .bus_req_o   (bus_req_o),
      .bus_addr_o  (bus_addr_o),
      .bus_gnt_i   (bus_gnt_i),
      .bus_rvalid_i(bus_rvalid_i),
      .bus_rdata_i (bus_rdata_i),
      .inst_o      (inst_o),
      .inst_valid_o(inst_valid_o),
      .adel_o      (adel_o),
`ifdef INST_FETCH_TIMEOUT_EN
      .bus_err_o   (bus_err_o),
`endif
      .stallreq_o  (stallreq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle so outputs are sampled away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int          done_cyc [2];
   logic [31:0] done_dat [2];
   logic [31:0] req_addr2;
   int          n_done;
   int          n_req;

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      rst          = 1'b1;
      pc_i         = '0;
      ce_i         = 1'b0;
      flush        = 1'b0;
      stall_i      = 1'b0;
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = '0;

      // Reset values
      step();
      step();
      check_eq("rst_req", bus_req_o, 0);
      check_eq("rst_addr", bus_addr_o, 0);
      check_eq("rst_inst", inst_o, 0);
      check_eq("rst_valid", inst_valid_o, 0);
      check_eq("rst_adel", adel_o, 0);
      check_eq("rst_stallreq", stallreq_o, 0);
      rst = 1'b0;

      // Basic fetch: grant on cycle 2, rvalid on cycle 4
      ce_i = 1'b1;
      pc_i = 32'hbfc00000;
      #1;
      check_eq("basic_stall_idle", stallreq_o, 1);
      step();
      check_eq("basic_req", bus_req_o, 1);
      check_eq("basic_addr", bus_addr_o, 32'hbfc00000);
      check_eq("basic_stall_req", stallreq_o, 1);
      ce_i      = 1'b0;
      bus_gnt_i = 1'b1;
      step();
      check_eq("basic_req_drop", bus_req_o, 0);
      check_eq("basic_stall_wait", stallreq_o, 1);
      bus_gnt_i = 1'b0;
      step();
      check_eq("basic_wait_valid", inst_valid_o, 0);
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = 32'h24010001;
      step();
      check_eq("basic_valid", inst_valid_o, 1);
      check_eq("basic_inst", inst_o, 32'h24010001);
      check_eq("basic_adel", adel_o, 0);
      check_eq("basic_stall_done", stallreq_o, 0);
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = '0;
      step();
      check_eq("basic_consumed", inst_valid_o, 0);

      // Back-to-back fetches with grant and rvalid together
      ce_i         = 1'b1;
      pc_i         = 32'hbfc00000;
      bus_gnt_i    = 1'b1;
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = 32'h3c1dbfc1;
      n_done       = 0;
      n_req        = 0;
      req_addr2    = '0;
      done_cyc[0]  = 0;
      done_cyc[1]  = 0;
      done_dat[0]  = '0;
      done_dat[1]  = '0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (bus_req_o) begin
            n_req++;
            if (n_req == 2) req_addr2 = bus_addr_o;
         end
         if (inst_valid_o && n_done < 2) begin
            done_cyc[n_done] = i;
            done_dat[n_done] = inst_o;
            n_done++;
            if (n_done == 1) begin
               pc_i        = 32'hbfc00004;
               bus_rdata_i = 32'h8fa40010;
            end else begin
               ce_i = 1'b0;
            end
         end
      end
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'b0;
      check_eq("b2b_count", n_done, 2);
      check_eq("b2b_spacing", done_cyc[1] - done_cyc[0], 3);
      check_eq("b2b_data0", done_dat[0], 32'h3c1dbfc1);
      check_eq("b2b_data1", done_dat[1], 32'h8fa40010);
      check_eq("b2b_addr1", req_addr2, 32'hbfc00004);

      // Misaligned fetch: no bus access, address error flagged
      ce_i = 1'b1;
      pc_i = 32'hbfc00002;
      step();
      check_eq("mis_valid", inst_valid_o, 1);
      check_eq("mis_adel", adel_o, 1);
      check_eq("mis_inst", inst_o, 0);
      check_eq("mis_req", bus_req_o, 0);
      ce_i = 1'b0;
      step();
      check_eq("mis_consumed", {inst_valid_o, bus_req_o}, 2'b00);

      // Flush while request is pending: grant+rvalid response is dropped
      ce_i = 1'b1;
      pc_i = 32'hbfc00010;
      step();
      ce_i  = 1'b0;
      flush = 1'b1;
      step();
      check_eq("freq_held", bus_req_o, 1);
      check_eq("freq_addr", bus_addr_o, 32'hbfc00010);
      flush        = 1'b0;
      bus_gnt_i    = 1'b1;
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = 32'hcafef00d;
      step();
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'b0;
      check_eq("freq_valid", inst_valid_o, 0);
      check_eq("freq_req", bus_req_o, 0);
      check_eq("freq_inst", inst_o, 0);
      check_eq("freq_stall", stallreq_o, 0);

      // Flush in WAIT: late response swallowed, next fetch uses the new pc
      ce_i = 1'b1;
      pc_i = 32'hbfc00100;
      step();
      ce_i      = 1'b0;
      bus_gnt_i = 1'b1;
      step();
      bus_gnt_i = 1'b0;
      flush     = 1'b1;
      step();
      flush = 1'b0;
      #1;
      check_eq("fwait_stall_discard", stallreq_o, 1);
      step();
      step();
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = 32'hdeadbeef;
      step();
      bus_rvalid_i = 1'b0;
      check_eq("fwait_valid", inst_valid_o, 0);
      check_eq("fwait_inst", inst_o, 0);
      check_eq("fwait_stall_idle", stallreq_o, 0);
      ce_i = 1'b1;
      pc_i = 32'hbfc00380;
      step();
      check_eq("fwait_req", bus_req_o, 1);
      check_eq("fwait_addr", bus_addr_o, 32'hbfc00380);
      ce_i         = 1'b0;
      bus_gnt_i    = 1'b1;
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = 32'h8fbf0010;
      step();
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'b0;
      check_eq("fwait_next_inst", {inst_valid_o, inst_o}, {1'b1, 32'h8fbf0010});
      step();

      // Downstream hold in DONE
      ce_i         = 1'b1;
      pc_i         = 32'hbfc00200;
      bus_gnt_i    = 1'b1;
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = 32'h8c220000;
      step();
      step();
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'b0;
      stall_i      = 1'b1;
      pc_i         = 32'hbfc00204;
      #1;
      check_eq("hold_stallreq", stallreq_o, 0);
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq("hold", {inst_valid_o, bus_req_o, inst_o}, {1'b1, 1'b0, 32'h8c220000});
      end
      stall_i = 1'b0;
      step();
      check_eq("hold_release", {inst_valid_o, bus_req_o}, 2'b00);
      step();
      check_eq("hold_next_req", {bus_req_o, bus_addr_o}, {1'b1, 32'hbfc00204});
      ce_i         = 1'b0;
      bus_gnt_i    = 1'b1;
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = 32'h00000011;
      step();
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'b0;
      check_eq("hold_next_inst", inst_o, 32'h00000011);

      // Flush in DONE overrides a downstream stall
      stall_i = 1'b1;
      flush   = 1'b1;
      step();
      check_eq("fdone_valid", inst_valid_o, 0);
      flush   = 1'b0;
      stall_i = 1'b0;
      step();

`ifdef INST_FETCH_TIMEOUT_EN
      // Timeout: grant with no data completes as an error after 4 WAIT cycles
      ce_i = 1'b1;
      pc_i = 32'hbfc00400;
      step();
      ce_i      = 1'b0;
      bus_gnt_i = 1'b1;
      step();
      bus_gnt_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("to_wait", {inst_valid_o, bus_err_o}, 2'b00);
      end
      step();
      check_eq("to_done", {inst_valid_o, bus_err_o}, 2'b11);
      check_eq("to_inst", inst_o, 0);
      step();
      check_eq("to_clear", {inst_valid_o, bus_err_o}, 2'b00);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
